// File: rtl/sound_pkg.sv
// Shared definitions for the sound controller channels.
// Holds the CH4 register addresses, the CH4 frequency divisor table,
// frame-sequencer step masks, register field layouts and the CH4
// frequency-timer reload helper.
package sound_pkg;

    localparam logic [15:0] NR41_ADDR = 16'hFF20;
    localparam logic [15:0] NR42_ADDR = 16'hFF21;
    localparam logic [15:0] NR43_ADDR = 16'hFF22;
    localparam logic [15:0] NR44_ADDR = 16'hFF23;

    // A set bit n means the frame sequencer emits that clock on step n.
    localparam logic [7:0] LEN_STEPS = 8'b0101_0101;
    localparam logic [7:0] ENV_STEPS = 8'b1000_0000;

    localparam logic [6:0] CH4_DIVISOR [0:7] = '{
        7'd8, 7'd16, 7'd32, 7'd48, 7'd64, 7'd80, 7'd96, 7'd112
    };

    // NR42: envelope control.
    typedef struct packed {
        logic [3:0] vol;
        logic       env_up;
        logic [2:0] period;
    } nr42_t;

    // NR43: polynomial counter control.
    typedef struct packed {
        logic [3:0] shift;
        logic       width7;
        logic [2:0] div_code;
    } nr43_t;

    // Largest reload is 112 << 13, which fits in 20 bits. Shift codes 14
    // and 15 stop the timer, so their reload value is never consumed.
    function automatic logic [19:0] ch4_freq_reload(input logic [2:0] div_code,
                                                    input logic [3:0] shift);
        if (shift >= 4'd14) return 20'd0;
        return 20'(CH4_DIVISOR[div_code]) << shift;
    endfunction

endpackage

// File: rtl/sound_ctlr_ch4_regs_if.sv
// CPU register bus for the CH4 front-end.
//   write_enable : one-cycle write strobe
//   addr         : CPU address
//   wdata        : write data
//   rdata        : combinational read data for addr
interface sound_ctlr_ch4_regs_if;
    logic        write_enable;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;

    modport master (output write_enable, addr, wdata, input rdata);
    modport slave  (input write_enable, addr, wdata, output rdata);
endinterface

// File: rtl/sound_frame_sequencer.sv
// Frame sequencer shared by the sound channels.
// Divides iClock by FS_DIV and walks an 8-step sequence; emits one-cycle
// length and envelope clock pulses on the steps selected by the masks.
//   iClock  : system clock
//   iReset  : asynchronous active-low reset
//   oLenClk : length-counter clock pulse (steps 0,2,4,6)
//   oEnvClk : envelope clock pulse (step 7)
module sound_frame_sequencer
    import sound_pkg::*;
#(
    parameter int FS_DIV = 8192,
    parameter int FS_W   = 13
) (
    input  logic iClock,
    input  logic iReset,
    output logic oLenClk,
    output logic oEnvClk
);

    logic [FS_W-1:0] prescaler;
    logic [2:0]      step;
    logic            wrap;

    assign wrap = (prescaler == FS_W'(FS_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            prescaler <= '0;
            step      <= 3'd0;
            oLenClk   <= 1'b0;
            oEnvClk   <= 1'b0;
        end else begin
            // The pulse belongs to the step that is ending on this wrap.
            oLenClk <= wrap && LEN_STEPS[step];
            oEnvClk <= wrap && ENV_STEPS[step];
            if (wrap) begin
                prescaler <= '0;
                step      <= step + 3'd1;
            end else begin
                prescaler <= prescaler + FS_W'(1);
            end
        end
    end

endmodule

// File: rtl/sound_ctlr_ch4_regs.sv
// Sound channel 4 (noise) register and timing front-end.
// Decodes NR41..NR44, runs length/envelope/frequency timers, drives the
// noise LFSR step/reload strobes and produces the registered 4-bit sample.
//   iClock      : system clock
//   iReset      : asynchronous active-low reset
//   bus         : CPU register bus (slave side, combinational read data)
//   iLfsrBit    : current LFSR output bit
//   oLfsrStep   : one-cycle pulse, shift the LFSR
//   oLfsrReload : one-cycle pulse on trigger, LFSR reloads to all ones
//   oLfsrWidth7 : 7-bit LFSR mode select
//   oSample     : channel amplitude 0..15
//   oActive     : channel-on status
module sound_ctlr_ch4_regs
    import sound_pkg::*;
#(
    parameter int FS_DIV = 8192,
    parameter int FS_W   = 13
) (
    input  logic                       iClock,
    input  logic                       iReset,
    sound_ctlr_ch4_regs_if.slave       bus,
    input  logic                       iLfsrBit,
    output logic                       oLfsrStep,
    output logic                       oLfsrReload,
    output logic                       oLfsrWidth7,
    output logic [3:0]                 oSample,
    output logic                       oActive
);

    nr42_t       nr42;
    nr43_t       nr43;
    logic        len_en;
    logic [6:0]  length;
    logic [3:0]  vol;
    logic [3:0]  vol_next;
    logic [2:0]  env_timer;
    logic [19:0] freq_timer;
    logic [19:0] freq_reload;
    logic        len_clk;
    logic        env_clk;

    logic wr_nr41, wr_nr42, wr_nr43, wr_nr44;
    logic trigger, dac_on, freq_hold, len_tick;

    sound_frame_sequencer #(.FS_DIV(FS_DIV), .FS_W(FS_W)) u_fs (
        .iClock  (iClock),
        .iReset  (iReset),
        .oLenClk (len_clk),
        .oEnvClk (env_clk)
    );

    assign wr_nr41     = bus.write_enable && (bus.addr == NR41_ADDR);
    assign wr_nr42     = bus.write_enable && (bus.addr == NR42_ADDR);
    assign wr_nr43     = bus.write_enable && (bus.addr == NR43_ADDR);
    assign wr_nr44     = bus.write_enable && (bus.addr == NR44_ADDR);
    assign trigger     = wr_nr44 && bus.wdata[7];
    assign dac_on      = (nr42.vol != 4'd0) || nr42.env_up;
    assign freq_hold   = (nr43.shift >= 4'd14);
    assign freq_reload = ch4_freq_reload(nr43.div_code, nr43.shift);
    assign oLfsrWidth7 = nr43.width7;
    // A coinciding NR41 write or trigger overrides the length clock.
    assign len_tick    = len_clk && len_en && (length != 7'd0) && !wr_nr41 && !trigger;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        bus.rdata = 8'hFF;
        case (bus.addr)
            NR42_ADDR: bus.rdata = nr42;
            NR43_ADDR: bus.rdata = nr43;
            NR44_ADDR: bus.rdata = {1'b1, len_en, 6'h3F};
            default:   bus.rdata = 8'hFF;
        endcase
    end

    always_comb begin
        vol_next = vol;
        if (nr42.env_up && (vol != 4'd15))       vol_next = vol + 4'd1;
        else if (!nr42.env_up && (vol != 4'd0))  vol_next = vol - 4'd1;
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            nr42        <= '0;
            nr43        <= '0;
            len_en      <= 1'b0;
            length      <= 7'd0;
            oActive     <= 1'b0;
            vol         <= 4'd0;
            env_timer   <= 3'd0;
            freq_timer  <= 20'd0;
            oLfsrStep   <= 1'b0;
            oLfsrReload <= 1'b0;
            oSample     <= 4'd0;
        end else begin
            if (wr_nr42) nr42   <= nr42_t'(bus.wdata);
            if (wr_nr43) nr43   <= nr43_t'(bus.wdata);
            if (wr_nr44) len_en <= bus.wdata[6];

            // Length counter
            if (wr_nr41)                          length <= 7'd64 - {1'b0, bus.wdata[5:0]};
            else if (trigger && length == 7'd0)   length <= 7'd64;
            else if (len_tick)                    length <= length - 7'd1;

            // Channel status: a DAC-off write kills the channel at once.
            if (trigger)                                   oActive <= dac_on;
            else if (wr_nr42 && bus.wdata[7:3] == 5'd0)    oActive <= 1'b0;
            else if (len_tick && length == 7'd1)           oActive <= 1'b0;

            // Envelope: an NR42 write in the same cycle as the envelope
            // clock leaves the current volume untouched.
            if (trigger) begin
                vol       <= nr42.vol;
                env_timer <= nr42.period;
            end else if (env_clk && !wr_nr42 && nr42.period != 3'd0) begin
                if (env_timer <= 3'd1) begin
                    env_timer <= nr42.period;
                    vol       <= vol_next;
                end else begin
                    env_timer <= env_timer - 3'd1;
                end
            end

            // Frequency timer: zero means idle until the first trigger.
            oLfsrStep   <= 1'b0;
            oLfsrReload <= trigger;
            if (trigger) begin
                freq_timer <= freq_reload;
            end else if (!freq_hold && freq_timer != 20'd0) begin
                if (freq_timer == 20'd1) begin
                    freq_timer <= freq_reload;
                    oLfsrStep  <= 1'b1;
                end else begin
                    freq_timer <= freq_timer - 20'd1;
                end
            end

            oSample <= (oActive && !iLfsrBit) ? vol : 4'd0;
        end
    end

endmodule

// File: tb/tb_sound_ctlr_ch4_regs.sv
// Self-checking bench for sound_ctlr_ch4_regs. Uses a short frame-sequencer
// prescaler so length and envelope behaviour is reachable quickly.
module tb_sound_ctlr_ch4_regs;
    import sound_pkg::*;

    localparam int FS_DIV = 32;
    localparam int FS_W   = 5;
    localparam int ENV_PERIOD_CLK = 8 * FS_DIV;

    logic       iClock = 1'b0;
    logic       iReset = 1'b0;
    logic       iLfsrBit = 1'b0;
    logic       oLfsrStep, oLfsrReload, oLfsrWidth7, oActive;
    logic [3:0] oSample;

    sound_ctlr_ch4_regs_if bus ();

    sound_ctlr_ch4_regs #(.FS_DIV(FS_DIV), .FS_W(FS_W)) dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .bus         (bus),
        .iLfsrBit    (iLfsrBit),
        .oLfsrStep   (oLfsrStep),
        .oLfsrReload (oLfsrReload),
        .oLfsrWidth7 (oLfsrWidth7),
        .oSample     (oSample),
        .oActive     (oActive)
    );

    always #5 iClock = ~iClock;

    int unsigned cyc = 0;
    always @(posedge iClock) cyc <= cyc + 1;

    int          tests_run = 0;
    int          tests_failed = 0;
    int unsigned last_write_cyc = 0;
    int unsigned step_q[$];
    logic [3:0]  sample_q[$];
    logic [3:0]  vol_q[$];

    // Called at a falling edge; the write lands on the next rising edge and
    // the task returns on the falling edge after it.
    task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
        bus.addr         = a;
        bus.wdata        = d;
        bus.write_enable = 1'b1;
        last_write_cyc   = cyc + 1;
        @(negedge iClock);
        bus.write_enable = 1'b0;
        bus.addr         = 16'h0000;
    endtask

    task automatic read_reg(input logic [15:0] a, output logic [7:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    // Scoreboard for LFSR step pulses: expected cycles are queued up front,
    // each observed pulse pops and compares one entry.
    task automatic match_steps(input string name, input int unsigned t0,
                               input int unsigned period, input int unsigned window);
        int unsigned exp_n, seen_n, exp_t;
        step_q.delete();
        seen_n = 0;
        if (period != 0)
            for (int unsigned t = t0 + period; t <= t0 + window; t += period)
                step_q.push_back(t);
        exp_n = step_q.size();
        while (cyc < t0 + window) begin
            @(negedge iClock);
            if (oLfsrStep === 1'b1) begin
                seen_n++;
                tests_run++;
                if (step_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL %s_step_unexpected: step at +%0d, expected none", name, cyc - t0);
                end else begin
                    exp_t = step_q.pop_front();
                    if (cyc !== exp_t) begin
                        tests_failed++;
                        $display("FAIL %s_step_time: step at +%0d, expected +%0d", name, cyc - t0, exp_t - t0);
                    end
                end
            end
        end
        tests_run++;
        if (seen_n !== exp_n) begin
            tests_failed++;
            $display("FAIL %s_step_count: saw %0d steps, expected %0d", name, seen_n, exp_n);
        end
    endtask

    // Scoreboard for the sample stage: one cycle of latency from iLfsrBit.
    task automatic drive_samples(input string name, input logic [7:0] bits, input int n,
                                 input logic act, input logic [3:0] vol);
        logic [3:0] exp;
        for (int i = 0; i < n; i++) begin
            iLfsrBit = bits[i];
            sample_q.push_back((act && !bits[i]) ? vol : 4'h0);
            @(negedge iClock);
            exp = sample_q.pop_front();
            tests_run++;
            if (oSample !== exp) begin
                tests_failed++;
                $display("FAIL %s_sample[%0d]: got %h, expected %h", name, i, oSample, exp);
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        iReset = 1'b0;
        bus.write_enable = 1'b0;
        bus.addr = 16'h0000;
        bus.wdata = 8'h00;
        repeat (3) @(negedge iClock);
        tests_run++;
        if ({oActive, oSample, oLfsrStep, oLfsrReload, oLfsrWidth7} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b, expected 00000000",
                     {oActive, oSample, oLfsrStep, oLfsrReload, oLfsrWidth7});
        end
        read_reg(NR42_ADDR, d);
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_ff21: got %h, expected 00", d); end
        read_reg(NR44_ADDR, d);
        tests_run++;
        if (d !== 8'hBF) begin tests_failed++; $display("FAIL reset_ff23: got %h, expected bf", d); end
        read_reg(NR41_ADDR, d);
        tests_run++;
        if (d !== 8'hFF) begin tests_failed++; $display("FAIL read_ff20: got %h, expected ff", d); end
        read_reg(16'hFF24, d);
        tests_run++;
        if (d !== 8'hFF) begin tests_failed++; $display("FAIL read_unmapped: got %h, expected ff", d); end
        @(negedge iClock);
        iReset = 1'b1;
        @(negedge iClock);
    endtask

    task automatic test_trigger();
        int unsigned t0;
        iLfsrBit = 1'b0;
        write_reg(NR42_ADDR, 8'hF0);
        write_reg(NR43_ADDR, 8'h00);
        write_reg(NR44_ADDR, 8'h80);
        t0 = last_write_cyc;
        tests_run++;
        if ({oLfsrReload, oActive, oLfsrStep} !== 3'b110) begin
            tests_failed++;
            $display("FAIL trigger_strobes: reload,active,step=%b, expected 110",
                     {oLfsrReload, oActive, oLfsrStep});
        end
        @(negedge iClock);
        tests_run++;
        if (oLfsrReload !== 1'b0) begin tests_failed++; $display("FAIL reload_one_cycle: got %b, expected 0", oLfsrReload); end
        tests_run++;
        if (oSample !== 4'hF) begin tests_failed++; $display("FAIL trigger_sample: got %h, expected f", oSample); end
        match_steps("div8", t0, 8, 40);
        drive_samples("lfsr", 8'b0001_0010, 5, 1'b1, 4'hF);
        iLfsrBit = 1'b0;
    endtask

    task automatic test_back_to_back();
        int unsigned t1, t2;
        write_reg(NR44_ADDR, 8'h80);
        t1 = last_write_cyc;
        while (cyc < t1 + 7) @(negedge iClock);
        // This trigger lands on the cycle the timer would have expired.
        write_reg(NR44_ADDR, 8'h80);
        t2 = last_write_cyc;
        tests_run++;
        if ({oLfsrReload, oLfsrStep} !== 2'b10) begin
            tests_failed++;
            $display("FAIL trig_vs_expiry: reload,step=%b, expected 10", {oLfsrReload, oLfsrStep});
        end
        match_steps("b2b", t2, 8, 32);
    endtask

    task automatic test_length();
        logic [7:0] d;
        logic dropped;
        int unsigned t0;
        bit seen;
        write_reg(NR42_ADDR, 8'hF0);
        write_reg(NR41_ADDR, 8'h3F);
        write_reg(NR44_ADDR, 8'h80);
        dropped = 1'b0;
        repeat (3 * FS_DIV) begin
            @(negedge iClock);
            if (oActive !== 1'b1) dropped = 1'b1;
        end
        tests_run++;
        if (dropped !== 1'b0) begin tests_failed++; $display("FAIL length_disabled: channel dropped, expected stay on"); end
        write_reg(NR44_ADDR, 8'hC0);
        t0 = last_write_cyc;
        tests_run++;
        if (oActive !== 1'b1) begin tests_failed++; $display("FAIL length_trigger_active: got %b, expected 1", oActive); end
        read_reg(NR44_ADDR, d);
        tests_run++;
        if (d !== 8'hFF) begin tests_failed++; $display("FAIL ff23_len_en: got %h, expected ff", d); end
        seen = 0;
        while (!seen && cyc < t0 + 2 * FS_DIV + 4) begin
            @(negedge iClock);
            if (oActive === 1'b0) seen = 1;
        end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL length_expire: oActive still %b after %0d clk, expected 0", oActive, 2 * FS_DIV + 4); end
    endtask

    task automatic test_envelope();
        int unsigned t0, first_t;
        int first_dt;
        logic [3:0] prev, exp;
        iLfsrBit = 1'b0;
        write_reg(NR42_ADDR, 8'h0A);
        write_reg(NR44_ADDR, 8'h80);
        t0 = last_write_cyc;
        repeat (2) @(negedge iClock);
        tests_run++;
        if ({oActive, oSample} !== 5'b1_0000) begin
            tests_failed++;
            $display("FAIL env_start: active,sample=%b, expected 10000", {oActive, oSample});
        end
        vol_q.delete();
        for (int v = 1; v <= 15; v++) vol_q.push_back(4'(v));
        prev = 4'h0;
        first_t = 0;
        while (cyc < t0 + 37 * ENV_PERIOD_CLK) begin
            @(negedge iClock);
            if (oSample !== prev) begin
                tests_run++;
                if (vol_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL env_unexpected: vol %h -> %h, expected hold at f", prev, oSample);
                end else begin
                    exp = vol_q.pop_front();
                    if (oSample !== exp) begin
                        tests_failed++;
                        $display("FAIL env_step: got %h, expected %h", oSample, exp);
                    end
                end
                if (first_t == 0) first_t = cyc;
                prev = oSample;
            end
        end
        first_dt = (first_t == 0) ? -1 : int'(first_t) - int'(t0);
        tests_run++;
        if (first_dt < ENV_PERIOD_CLK || first_dt > 2 * ENV_PERIOD_CLK + 8) begin
            tests_failed++;
            $display("FAIL env_period2: first step at +%0d, expected %0d..%0d",
                     first_dt, ENV_PERIOD_CLK, 2 * ENV_PERIOD_CLK + 8);
        end
        tests_run++;
        if (vol_q.size() !== 0) begin tests_failed++; $display("FAIL env_ramp: %0d steps missing, expected 0", vol_q.size()); end
        tests_run++;
        if (oSample !== 4'hF) begin tests_failed++; $display("FAIL env_saturate: got %h, expected f", oSample); end
    endtask

    task automatic test_freq_shift();
        logic [7:0] d;
        write_reg(NR42_ADDR, 8'hF0);
        write_reg(NR43_ADDR, 8'h71);
        write_reg(NR44_ADDR, 8'h80);
        tests_run++;
        if (oLfsrWidth7 !== 1'b0) begin tests_failed++; $display("FAIL width7_off: got %b, expected 0", oLfsrWidth7); end
        match_steps("shift7", last_write_cyc, 2048, 4200);
        write_reg(NR43_ADDR, 8'hE8);
        read_reg(NR43_ADDR, d);
        tests_run++;
        if (d !== 8'hE8) begin tests_failed++; $display("FAIL ff22_read: got %h, expected e8", d); end
        tests_run++;
        if (oLfsrWidth7 !== 1'b1) begin tests_failed++; $display("FAIL width7_on: got %b, expected 1", oLfsrWidth7); end
        @(negedge iClock);
        write_reg(NR44_ADDR, 8'h80);
        match_steps("shift14", last_write_cyc, 0, 20000);
    endtask

    task automatic test_dac_off();
        logic [7:0] d;
        write_reg(NR42_ADDR, 8'hF0);
        write_reg(NR43_ADDR, 8'h00);
        write_reg(NR44_ADDR, 8'h80);
        write_reg(NR42_ADDR, 8'h00);
        tests_run++;
        if (oActive !== 1'b0) begin tests_failed++; $display("FAIL dac_off_active: got %b, expected 0", oActive); end
        write_reg(NR44_ADDR, 8'h80);
        tests_run++;
        if ({oActive, oLfsrReload} !== 2'b01) begin
            tests_failed++;
            $display("FAIL dac_off_trigger: active,reload=%b, expected 01", {oActive, oLfsrReload});
        end
        read_reg(NR44_ADDR, d);
        tests_run++;
        if (d !== 8'hBF) begin tests_failed++; $display("FAIL ff23_no_len: got %h, expected bf", d); end
        @(negedge iClock);
        write_reg(NR44_ADDR, 8'h40);
        read_reg(NR44_ADDR, d);
        tests_run++;
        if (d !== 8'hFF) begin tests_failed++; $display("FAIL ff23_len: got %h, expected ff", d); end
        @(negedge iClock);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        bit found, noisy;
        iLfsrBit = 1'b0;
        write_reg(NR42_ADDR, 8'hF0);
        write_reg(NR44_ADDR, 8'h80);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge iClock);
            if (oLfsrStep === 1'b1) found = 1;
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL reset_mid_setup: no step in 20 clk, expected one"); end
        #1 iReset = 1'b0;
        #1;
        tests_run++;
        if ({oActive, oSample, oLfsrStep} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: active,sample,step=%b, expected 000000", {oActive, oSample, oLfsrStep});
        end
        read_reg(NR42_ADDR, d);
        tests_run++;
        if (d !== 8'h00) begin tests_failed++; $display("FAIL reset_mid_ff21: got %h, expected 00", d); end
        @(negedge iClock);
        iReset = 1'b1;
        noisy = 0;
        repeat (20) begin
            @(negedge iClock);
            if (oLfsrStep !== 1'b0 || oLfsrReload !== 1'b0 || oActive !== 1'b0) noisy = 1;
        end
        tests_run++;
        if (noisy) begin tests_failed++; $display("FAIL reset_mid_quiet: strobe or active after reset, expected none"); end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_back_to_back();
        test_length();
        test_envelope();
        test_freq_shift();
        test_dac_off();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
